il_frame_scheduler: RTL

//  Shares one interleaver datapath among N_REQ frame requesters. Each requester

---
 rtl/il_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/il_frame_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/il_pkg.sv
// Shared types and helpers for the interleaver frame scheduler.
package il_pkg;

    localparam int IL_FRAME_W = 35;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } il_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above i_ptr, wrapping.
module rr_arbiter
    import il_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    localparam logic [ID_W:0] NR = (ID_W + 1)'(N_REQ);

    logic [ID_W:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = {1'b0, i_ptr} + k[ID_W:0];
            if (w_pos >= NR) w_pos = w_pos - NR;
            if (!o_any && i_req[w_pos[ID_W-1:0]]) begin
                o_any                    = 1'b1;
                o_idx                    = w_pos[ID_W-1:0];
                o_gnt[w_pos[ID_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/il_frame_scheduler.sv
// Round-robin scheduler sharing one interleaver among N_REQ frame requesters.
//   state   | meaning
//   IDLE    | arbitrate; latch granted frame and id, strobe req_ready
//   ISSUE   | pulse il_en, clear watchdog
//   WAIT    | wait for il_done or watchdog expiry
//   DELIVER | hold result until out_ready
module il_frame_scheduler
    import il_pkg::*;
#(
    parameter  int N_REQ   = 2,
    parameter  int FRAME_W = IL_FRAME_W,
    parameter  int TIMEOUT = 15,
    localparam int ID_W    = clog2_min1(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*FRAME_W-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     il_en,
    output logic [FRAME_W-1:0]       il_data,
    input  logic                     il_done,
    input  logic [FRAME_W-1:0]       il_result,
    output logic                     out_valid,
    output logic [ID_W-1:0]          out_id,
    output logic [FRAME_W-1:0]       out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int              WD_W    = clog2_min1(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

    il_state_t          r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gid;
    logic [WD_W-1:0]    r_wdog;
    logic [N_REQ-1:0]   r_req_ready;
    logic               r_il_en;
    logic [FRAME_W-1:0] r_il_data;
    logic               r_out_valid;
    logic [ID_W-1:0]    r_out_id;
    logic [FRAME_W-1:0] r_out_data;
    logic               r_timeout_err;

    logic [N_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [FRAME_W-1:0] w_frame;
    logic [ID_W-1:0]    w_ptr_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_frame = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) w_frame = req_data[i*FRAME_W +: FRAME_W];
        end
    end

    assign w_ptr_nxt = (r_gid == ID_LAST) ? '0 : r_gid + 1'b1;

    // Strobes default low every cycle; only the FSM branches raise them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_gid         <= '0;
            r_wdog        <= '0;
            r_req_ready   <= '0;
            r_il_en       <= 1'b0;
            r_il_data     <= '0;
            r_out_valid   <= 1'b0;
            r_out_id      <= '0;
            r_out_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_req_ready   <= '0;
            r_il_en       <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_req_ready <= w_gnt;
                        r_gid       <= w_idx;
                        r_il_data   <= w_frame;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_il_en <= 1'b1;
                    r_wdog  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (il_done) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= il_result;
                        r_out_id    <= r_gid;
                        r_state     <= DELIVER;
                    end else if (r_wdog == WD_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_ptr         <= w_ptr_nxt;
                        r_state       <= IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                DELIVER: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_ptr       <= w_ptr_nxt;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign il_en       = r_il_en;
    assign il_data     = r_il_data;
    assign out_valid   = r_out_valid;
    assign out_id      = r_out_id;
    assign out_data    = r_out_data;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != IDLE);

endmodule
